// File: rtl/multicycle_controller.sv
// Multicycle RISC-V main controller: Moore sequencing FSM plus ALU and immediate decode.
// Write enables are masked while rst is high so nothing commits during reset.
//
// state     | meaning
// ----------+-----------------------------------------------
// FETCH     | read instruction at PC, PC <= PC + 4
// DECODE    | register read, branch/jump target = OldPC + imm
// MEM_ADR   | effective address = A + imm
// MEM_READ  | read data memory at ALUOut
// MEM_WB    | write loaded data to register file
// MEM_WRITE | write B to data memory at ALUOut
// EXEC_R    | register-register ALU operation
// ALU_WB    | write ALUOut to register file
// EXEC_I    | register-immediate ALU operation
// JAL       | PC <= target, ALUOut <= OldPC + 4 for link
// BEQ       | compare A and B, PC <= target when equal
module multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [2:0] ALUControl,
    output logic [2:0] ImmSrc,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADR   = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_ALU_WB    = 4'd7,
        S_EXEC_I    = 4'd8,
        S_JAL       = 4'd9,
        S_BEQ       = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    state_t     state_q;
    state_t     state_d;
    logic [2:0] alu_dec;
    logic       pc_write_raw;
    logic       ir_write_raw;
    logic       mem_write_raw;
    logic       reg_write_raw;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    assign state = state_q;

    always_comb begin
        alu_dec = ALU_ADD;
        case (funct3)
            3'b000:  alu_dec = (op == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_dec = ALU_SLT;
            3'b110:  alu_dec = ALU_OR;
            3'b111:  alu_dec = ALU_AND;
            default: alu_dec = ALU_ADD;
        endcase
    end

    always_comb begin
        ImmSrc = 3'b000;
        case (op)
            OP_SW:   ImmSrc = 3'b001;
            OP_BEQ:  ImmSrc = 3'b010;
            OP_JAL:  ImmSrc = 3'b011;
            default: ImmSrc = 3'b000;
        endcase
    end

    always_comb begin
        state_d       = S_FETCH;
        pc_write_raw  = 1'b0;
        ir_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        AdrSrc        = 1'b0;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        ResultSrc     = 2'b00;
        ALUControl    = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                ir_write_raw = 1'b1;
                pc_write_raw = 1'b1;
                ALUSrcB      = 2'b10;
                ResultSrc    = 2'b10;
                state_d      = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEM_ADR;
                    OP_R:         state_d = S_EXEC_R;
                    OP_I:         state_d = S_EXEC_I;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEM_ADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                AdrSrc  = 1'b1;
                state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                ResultSrc     = 2'b01;
                reg_write_raw = 1'b1;
            end
            S_MEM_WRITE: begin
                AdrSrc        = 1'b1;
                mem_write_raw = 1'b1;
            end
            S_EXEC_R: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_dec;
                state_d    = S_ALU_WB;
            end
            S_EXEC_I: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_dec;
                state_d    = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write_raw = 1'b1;
            end
            S_JAL: begin
                ALUSrcA      = 2'b01;
                ALUSrcB      = 2'b10;
                pc_write_raw = 1'b1;
                state_d      = S_ALU_WB;
            end
            S_BEQ: begin
                // Branch decision is taken combinationally from the ALU flag this cycle.
                ALUSrcA      = 2'b10;
                ALUControl   = ALU_SUB;
                pc_write_raw = zero;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign PCWrite  = pc_write_raw  & ~rst;
    assign IRWrite  = ir_write_raw  & ~rst;
    assign MemWrite = mem_write_raw & ~rst;
    assign RegWrite = reg_write_raw & ~rst;

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 op  in  7  instruction opcode, IR[6:0].
REQ-005 funct3  in  3  IR[14:12].
REQ-006 funct7b5  in  1  IR[30].
REQ-007 zero  in  1  ALU zero flag.
REQ-008 PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc  out  1 each  write enables, memory address select (0=PC, 1=ALUOut).
REQ-009 ALUSrcA  out  2  4-way mux select: 00 PC, 01 OldPC, 10 A register, 11 unused (zero).
REQ-010 ALUSrcB  out  2  4-way mux select: 00 B register, 01 ImmExt, 10 constant 4, 11 unused (zero).
REQ-011 ResultSrc  out  2  4-way mux select: 00 ALUOut, 01 Data register, 10 ALUResult.
REQ-012 ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-013 ImmSrc  out  3  000 I, 001 S, 010 B, 011 J.
REQ-014 state  out  4  current state, for debug/verification.

Function
REQ-015 Moore FSM; state encoding: FETCH 0, DECODE 1, MEM_ADR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXEC_R 6, ALU_WB 7, EXEC_I 8, JAL 9, BEQ 10; codes 11-15 SHALL go to FETCH on the next edge with all enables 0.
REQ-016 Every output not listed for a state SHALL be 0.
REQ-017 FETCH: AdrSrc=0, IRWrite=1, PCWrite=1, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10; next DECODE.
REQ-018 DECODE: ALUSrcA=01, ALUSrcB=01, add; next per op: 0000011/0100011 MEM_ADR, 0110011 EXEC_R, 0010011 EXEC_I, 1101111 JAL, 1100011 BEQ, any other FETCH (no write issued).
REQ-019 MEM_ADR: ALUSrcA=10, ALUSrcB=01, add; next MEM_READ if op=0000011, else MEM_WRITE.
REQ-020 MEM_READ: ResultSrc=00, AdrSrc=1; next MEM_WB.
REQ-021 MEM_WB: ResultSrc=01, RegWrite=1; next FETCH.
REQ-022 MEM_WRITE: ResultSrc=00, AdrSrc=1, MemWrite=1; next FETCH.
REQ-023 EXEC_R: ALUSrcA=10, ALUSrcB=00, ALU decode; next ALU_WB.
REQ-024 EXEC_I: ALUSrcA=10, ALUSrcB=01, ALU decode; next ALU_WB.
REQ-025 ALU_WB: ResultSrc=00, RegWrite=1; next FETCH.
REQ-026 JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1; next ALU_WB.
REQ-027 BEQ: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, PCWrite=zero (same cycle, combinational); next FETCH.
REQ-028 ALU decode (EXEC_R/EXEC_I only): funct3 000 -> sub if op=0110011 and funct7b5=1, else add; 010 slt; 110 or; 111 and; other funct3 -> add.
REQ-029 ImmSrc SHALL be combinational from op in every state: 0100011 S, 1100011 B, 1101111 J, all others I.
REQ-030 Latency from FETCH to FETCH: lw 5, sw 4, R 4, I 4, jal 4, beq 3, illegal 2 cycles.

Reset
REQ-031 rst=1 at a rising edge SHALL set state=FETCH regardless of current state, including mid-instruction.
REQ-032 While rst=1, PCWrite, IRWrite, MemWrite, RegWrite SHALL be forced 0; other outputs follow state.
REQ-033 After rst deasserts, first edge SHALL move FETCH->DECODE.

Verification
REQ-034 Reset, op=0000011 (lw) -> states 0,1,2,3,4,0; RegWrite=1 and ResultSrc=01 only in state 4; AdrSrc=1 in state 3.
REQ-035 op=0100011 (sw) -> states 0,1,2,5,0; MemWrite=1 exactly one cycle (state 5); RegWrite never 1.
REQ-036 op=0110011, funct3=000, funct7b5=1 -> EXEC_R ALUControl=001; funct3=111 -> 010; op=0010011, funct3=000, funct7b5=1 -> 000.
REQ-037 op=1100011 with zero=1 -> PCWrite=1 in BEQ; zero=0 -> PCWrite=0; both return to FETCH after 3 cycles.
REQ-038 op=1101111 -> states 0,1,9,7,0, PCWrite=1 in state 9; op=1111111 -> 0,1,0 with no enables in DECODE.
REQ-039 rst=1 asserted while in MEM_READ -> next edge state=0, all enables 0 while rst high.
